// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: queues dual-lane commit outcomes in program
// order and trains the predictor with at most one update per cycle.
module bp_update_sched #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              c0_valid,
  input  logic              c0_hit,
  input  logic [31:0]       c0_pc,
  input  logic              c1_valid,
  input  logic              c1_hit,
  input  logic [31:0]       c1_pc,
  output logic              c_ready,
  output logic              pdc_valid,
  output logic              pdc_hit,
  output logic [31:0]       pdc_pc,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pdc_valid_q, pdc_valid_d;
  logic             pdc_hit_q, pdc_hit_d;
  logic [31:0]      pdc_pc_q, pdc_pc_d;
  logic             overflow_q, overflow_d;

  logic             pushEn;
  logic             popEn;
  logic             dropped;
  logic [1:0]       pushCnt;
  logic [32:0]      firstEntry;
  logic [32:0]      headEntry;

  // Room for two entries is required so a dual commit can never be half-accepted.
  assign c_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));

  always_comb begin
    pushEn      = 1'b0;
    popEn       = 1'b0;
    dropped     = 1'b0;
    pushCnt     = 2'd0;
    firstEntry  = c0_valid ? {c0_hit, c0_pc} : {c1_hit, c1_pc};
    headEntry   = mem[rd_ptr_q];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pdc_valid_d = pdc_valid_q;
    pdc_hit_d   = pdc_hit_q;
    pdc_pc_d    = pdc_pc_q;
    overflow_d  = overflow_q;

    if (rdy) begin
      pushEn  = c_ready;
      dropped = !c_ready && (c0_valid || c1_valid);
      popEn   = (count_q != '0);
      if (pushEn) begin
        pushCnt = {c0_valid & c1_valid, c0_valid ^ c1_valid};
      end
      wr_ptr_d    = wr_ptr_q + PTR_W'(pushCnt);
      rd_ptr_d    = rd_ptr_q + PTR_W'(popEn);
      count_d     = count_q + (PTR_W+1)'(pushCnt) - (PTR_W+1)'(popEn);
      pdc_valid_d = popEn;
      if (popEn) begin
        pdc_hit_d = headEntry[32];
        pdc_pc_d  = headEntry[31:0];
      end
      overflow_d = overflow_q | dropped;
    end
  end

  // Storage has no reset; occupancy and pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (rst && pushEn) begin
      if (pushCnt != 2'd0) begin
        mem[wr_ptr_q] <= firstEntry;
      end
      if (pushCnt == 2'd2) begin
        mem[wr_ptr_q + PTR_W'(1)] <= {c1_hit, c1_pc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pdc_valid_q <= 1'b0;
      pdc_hit_q   <= 1'b0;
      pdc_pc_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pdc_valid_q <= pdc_valid_d;
      pdc_hit_q   <= pdc_hit_d;
      pdc_pc_q    <= pdc_pc_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pdc_valid = pdc_valid_q;
  assign pdc_hit   = pdc_hit_q;
  assign pdc_pc    = pdc_pc_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Scheduler for the branch-predictor training port. Accepts resolved-branch outcomes from the two commit lanes of the reorder buffer, keeps them in program order in a small FIFO, and issues at most one update per cycle to the predictor's single update port (`ROB_input_valid` / `ROB_hit` / `ROB_pc`). Sits between the ReorderBuffer commit stage and the Predictor, decoupling dual commit from the predictor's one-write-per-cycle counter table.

## Interface

Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥ 4
- `PTR_W`, 3, log2(`DEPTH`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset)
- `rdy`  in  1  global enable; 0 freezes all state and outputs
- `c0_valid`  in  1  lane 0 (older) branch committed this cycle
- `c0_hit`  in  1  lane 0 outcome: 1 = taken
- `c0_pc`  in  32  lane 0 branch PC
- `c1_valid`  in  1  lane 1 (younger) branch committed this cycle
- `c1_hit`  in  1  lane 1 outcome: 1 = taken
- `c1_pc`  in  32  lane 1 branch PC
- `c_ready`  out  1  both lanes may push this cycle
- `pdc_valid`  out  1  update valid to predictor
- `pdc_hit`  out  1  taken flag to predictor
- `pdc_pc`  out  32  branch PC to predictor
- `count`  out  `PTR_W`+1  current FIFO occupancy
- `overflow`  out  1  sticky error: a push was lost

## Operation

- State: FIFO array of {hit, pc}, `wr_ptr`, `rd_ptr` (`PTR_W` bits, wrap modulo `DEPTH`), `count`, output registers, `overflow`.
- `c_ready` = (`count` ≤ `DEPTH`−2); combinational from registered `count` only. It does not depend on this cycle's pop.
- Push, when `rst`=1, `rdy`=1 and `c_ready`=1:
  - both lanes valid: c0 goes to `wr_ptr`, c1 to `wr_ptr`+1; `wr_ptr` += 2.
  - one lane valid, either lane: that entry goes to `wr_ptr`; `wr_ptr` += 1.
  - Program order is always c0 before c1.
- Push attempted with `c_ready`=0 (any valid lane):
  - entries are dropped; FIFO is unchanged.
  - `overflow` sets to 1 and stays 1 until reset.
- Pop, when `rdy`=1: if `count` > 0 (value before the edge), the head entry loads into `pdc_hit`/`pdc_pc`, `pdc_valid`←1, and `rd_ptr` += 1. Otherwise `pdc_valid`←0 and `pdc_hit`/`pdc_pc` hold.
- Simultaneous push and pop: `count` ← `count` + pushes − pop. Range is 0..`DEPTH`; never exceeds `DEPTH`.
- No bypass: an entry pushed at edge N can pop no earlier than edge N+1.
- `rdy`=0: no push, no pop, all registers hold, including `pdc_valid`. The predictor ignores its port while `rdy`=0, so a held update is not double-applied. Lane inputs presented while `rdy`=0 are ignored and do not set `overflow`.
- Reset, when `rst`=0 at an edge, even mid-drain: pointers 0, `count` 0, `pdc_valid` 0, `pdc_hit` 0, `pdc_pc` 0, `overflow` 0. Queued entries are discarded. `c_ready` = 1 after reset.

## Timing

- Push-to-predictor latency, empty FIFO: lane valid sampled at edge N, `pdc_valid`=1 during cycle after edge N+1.
- Drain rate: 1 update/cycle. Sustained dual commit fills the FIFO at net +1/cycle.
- `c_ready` falls the cycle after `count` reaches `DEPTH`−1. It rises the cycle after `count` drops to ≤ `DEPTH`−2.
- Wrap: dual push at `wr_ptr`=`DEPTH`−1 writes slots `DEPTH`−1 and 0.
- Each `pdc_valid` pulse lasts exactly one enabled cycle per entry; back-to-back entries give a continuous high.

## Test plan

- Reset, then single push c0 (hit=1, pc=0x100) at edge 1 → `pdc_valid`=1, `pdc_pc`=0x100, `pdc_hit`=1 after edge 2; `pdc_valid`=0 after edge 3; `count` back to 0.
- Dual push c0 pc=0x200 (hit 0) + c1 pc=0x204 (hit 1) → outputs 0x200/0 then 0x204/1 on consecutive cycles; order preserved.
- Dual push every cycle with `DEPTH`=8 → `count` 2,3,…,7; `c_ready` deasserts when `count`=7; further push sets `overflow`=1; sequence out equals accepted inputs only.
- Fill past slot 7 with a dual push at `wr_ptr`=7 → entries emerge in order across the wrap; no loss, `overflow`=0.
- `rdy`=0 for 3 cycles while `pdc_valid`=1 and `count`=3 → outputs, `count`, pointers frozen; lane valids ignored; drain resumes with the same next entry.
- Assert `rst`=0 for one edge with `count`=5 → all outputs 0, `c_ready`=1, no stale entry ever emerges.
